// File: rtl/sd_block_reader.sv
// sd_block_reader: turns a block request (LBA) into an SD SPI controller read
// command. It packs the 512 returned bytes big-endian into 32-bit words in a
// local buffer and streams them out over valid/ready while collection runs.
// Optional feature macro: SDREAD_CHECKSUM_EN adds CHECKSUM[15:0], the mod-2^16
// sum of all block bytes.
`timescale 1ns/1ps

module sd_block_reader #(
  parameter bit          BYTE_ADDR      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned BLOCK_BYTES    = 512
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] LBA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        CTRL_READ,
  output logic [31:0] ADDRESS,
  input  logic        CONTROLLER_READY,
  input  logic        BYTE_READY,
  input  logic [7:0]  READBUFFER,
  output logic        WORD_VALID,
  input  logic        WORD_READY,
  output logic [31:0] WORD_DATA,
  output logic        WORD_LAST
`ifdef SDREAD_CHECKSUM_EN
  ,
  output logic [15:0] CHECKSUM
`endif
);

  localparam int unsigned WORDS = BLOCK_BYTES / 4;
  localparam int unsigned PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_br_s1, r_br_s2, r_br_d;
  logic             r_cr_s1, r_cr_s2, r_cr_d;
  logic             r_ctrl_read, r_done, r_err, r_full;
  logic [31:0]      r_address;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [23:0]      r_pack;     // first three bytes of the word in flight
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]      r_mem [WORDS];
`ifdef SDREAD_CHECKSUM_EN
  logic [15:0]      r_checksum;
`endif

  logic w_byte_evt, w_cr_fall, w_accept, w_collect_evt, w_wr_en, w_last_byte;
  logic w_active, w_timeout, w_word_valid, w_xfer, w_last_xfer;

  assign w_byte_evt    = r_br_s2 & ~r_br_d;
  assign w_cr_fall     = r_cr_d & ~r_cr_s2;
  assign w_accept      = (r_state == S_REQ) && r_ctrl_read && w_cr_fall;
  assign w_collect_evt = (r_state == S_COLLECT) && w_byte_evt;
  assign w_wr_en       = w_collect_evt && (r_byte_cnt[1:0] == 2'b11);
  assign w_last_byte   = w_collect_evt && (r_byte_cnt == LAST_CNT);
  assign w_active      = (r_state == S_REQ) || (r_state == S_COLLECT);
  // Progress seen on the expiry cycle (accept or byte) wins over the timeout.
  assign w_timeout     = w_active && (r_timer == TMR_MAX) && !w_accept && !w_collect_evt;
  // The full flag disambiguates rd_ptr == wr_ptr once all words are written.
  assign w_word_valid  = ((r_state == S_COLLECT) || (r_state == S_DRAIN)) &&
                         ((r_rd_ptr != r_wr_ptr) || r_full);
  assign w_xfer        = w_word_valid && WORD_READY;
  assign w_last_xfer   = (r_state == S_DRAIN) && w_xfer && (r_rd_ptr == LAST_PTR);

  // Two-flop synchronisers plus one delay stage for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {r_br_s1, r_br_s2, r_br_d} <= '0;
      {r_cr_s1, r_cr_s2, r_cr_d} <= '0;
    end else begin
      {r_br_s1, r_br_s2, r_br_d} <= {BYTE_READY, r_br_s1, r_br_s2};
      {r_cr_s1, r_cr_s2, r_cr_d} <= {CONTROLLER_READY, r_cr_s1, r_cr_s2};
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (START) w_state_nxt = S_REQ;
      S_REQ:     if (w_timeout) w_state_nxt = S_IDLE;
                 else if (w_accept) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_timeout) w_state_nxt = S_IDLE;
                 else if (w_last_byte) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_last_xfer) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Command handshake, timeout, byte packing and buffer pointers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ctrl_read <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_full      <= 1'b0;
      r_address   <= '0;
      r_timer     <= '0;
      r_byte_cnt  <= '0;
      r_pack      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
`ifdef SDREAD_CHECKSUM_EN
      r_checksum  <= '0;
`endif
    end else begin
      r_done <= w_last_xfer;
      if (r_state == S_IDLE) begin
        if (START) begin
          r_address  <= BYTE_ADDR ? {LBA[22:0], 9'd0} : LBA;
          r_err      <= 1'b0;
          r_timer    <= '0;
          r_byte_cnt <= '0;
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          r_full     <= 1'b0;
`ifdef SDREAD_CHECKSUM_EN
          r_checksum <= '0;
`endif
        end
      end else if (w_timeout) begin
        // Abandon the block: nothing buffered is ever presented again.
        r_err       <= 1'b1;
        r_ctrl_read <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_full      <= 1'b0;
        r_byte_cnt  <= '0;
      end else begin
        if (w_active) r_timer <= (w_collect_evt || w_accept) ? '0 : r_timer + TMR_W'(1);
        if (r_state == S_REQ) begin
          if (w_accept)     r_ctrl_read <= 1'b0;
          else if (r_cr_s2) r_ctrl_read <= 1'b1;
        end
        if (w_collect_evt) begin
          r_pack     <= {r_pack[15:0], READBUFFER};
          r_byte_cnt <= r_byte_cnt + CNT_W'(1);
`ifdef SDREAD_CHECKSUM_EN
          r_checksum <= r_checksum + {8'd0, READBUFFER};
`endif
        end
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_xfer)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_xfer)
          r_full <= 1'b0;
        else if (w_wr_en && ((r_wr_ptr + PTR_W'(1)) == r_rd_ptr))
          r_full <= 1'b1;
        if (w_last_xfer) begin
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          r_full     <= 1'b0;
          r_byte_cnt <= '0;
        end
      end
    end
  end

  // Word buffer write; each word completes on its fourth byte.
  // NOTE: the buffer has no reset; pointers and the full flag define what is valid.
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {r_pack, READBUFFER};
  end

  assign BUSY       = (r_state != S_IDLE);
  assign DONE       = r_done;
  assign ERR        = r_err;
  assign CTRL_READ  = r_ctrl_read;
  assign ADDRESS    = r_address;
  assign WORD_VALID = w_word_valid;
  assign WORD_DATA  = w_word_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign WORD_LAST  = w_word_valid && (r_rd_ptr == LAST_PTR);
`ifdef SDREAD_CHECKSUM_EN
  assign CHECKSUM   = r_checksum;
`endif

endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader: directed bench for sd_block_reader. Two instances share
// stimulus: one byte-addressed (SDSC), one block-addressed (SDHC), both with a
// 100-cycle timeout. A small controller model serves bytes 0x00..0xFF twice.
`timescale 1ns/1ps

module tb_sd_block_reader;

  localparam int WORDS = 128;
  localparam int TMO   = 100;

  logic        CLK = 1'b0;
  logic        RST, START, CONTROLLER_READY, BYTE_READY, WORD_READY;
  logic [31:0] LBA;
  logic [7:0]  READBUFFER;

  logic        busy_a, done_a, err_a, ctrl_read_a, word_valid_a, word_last_a;
  logic [31:0] address_a, word_data_a;
  logic        busy_b, done_b, err_b, ctrl_read_b, word_valid_b, word_last_b;
  logic [31:0] address_b, word_data_b;
`ifdef SDREAD_CHECKSUM_EN
  logic [15:0] checksum_a, checksum_b;
`endif

  sd_block_reader #(.BYTE_ADDR(1'b1), .TIMEOUT_CYCLES(TMO), .BLOCK_BYTES(512)) u_dut_a (
    .CLK(CLK), .RST(RST), .START(START), .LBA(LBA),
    .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .CTRL_READ(ctrl_read_a),
    .ADDRESS(address_a), .CONTROLLER_READY(CONTROLLER_READY),
    .BYTE_READY(BYTE_READY), .READBUFFER(READBUFFER),
    .WORD_VALID(word_valid_a), .WORD_READY(WORD_READY),
    .WORD_DATA(word_data_a), .WORD_LAST(word_last_a)
`ifdef SDREAD_CHECKSUM_EN
    , .CHECKSUM(checksum_a)
`endif
  );

  sd_block_reader #(.BYTE_ADDR(1'b0), .TIMEOUT_CYCLES(TMO), .BLOCK_BYTES(512)) u_dut_b (
    .CLK(CLK), .RST(RST), .START(START), .LBA(LBA),
    .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .CTRL_READ(ctrl_read_b),
    .ADDRESS(address_b), .CONTROLLER_READY(CONTROLLER_READY),
    .BYTE_READY(BYTE_READY), .READBUFFER(READBUFFER),
    .WORD_VALID(word_valid_b), .WORD_READY(WORD_READY),
    .WORD_DATA(word_data_b), .WORD_LAST(word_last_b)
`ifdef SDREAD_CHECKSUM_EN
    , .CHECKSUM(checksum_b)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_vec  = 0;
  int n_miss = 0;

  // DONE pulse monitor.
  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge CLK) if (done_a) begin done_cnt++; done_cyc = cyc; end

  logic [31:0] got_a [WORDS];
  logic [31:0] got_b [WORDS];
  logic        got_last [WORDS];
  int          xfers, last_xfer_cyc, bytes_sent;
  bit          abort, bytes_done;
  logic [31:0] exp_addr_a, exp_addr_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    logic [7:0] b;
    b = 8'((4 * k) % 256);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  // Raise START for the cycle that samples it; returns just after that edge.
  task automatic start_req(input logic [31:0] lba);
    LBA   = lba;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic clear_capture();
    for (int k = 0; k < WORDS; k++) begin
      got_a[k] = '0; got_b[k] = '0; got_last[k] = 1'b0;
    end
    xfers = 0; bytes_sent = 0; bytes_done = 1'b0;
  endtask

  // Controller model: waits for CTRL_READ, accepts, then strobes nbytes bytes.
  task automatic ctrl_model(input int nbytes);
    int c = 0;
    while (!ctrl_read_a && c < 500) begin tick(); c++; end
    check("ctrl_read_seen", 32'(ctrl_read_a), 32'd1);
    check("address_a", address_a, exp_addr_a);
    check("address_b", address_b, exp_addr_b);
    CONTROLLER_READY = 1'b0;
    repeat (6) tick();
    check("ctrl_read_drop", 32'(ctrl_read_a), 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      if (abort) break;
      READBUFFER = i[7:0];
      BYTE_READY = 1'b1;
      repeat (3) tick();
      BYTE_READY = 1'b0;
      repeat (3) tick();
      bytes_sent = i + 1;
    end
    BYTE_READY       = 1'b0;
    CONTROLLER_READY = 1'b1;
    bytes_done       = 1'b1;
  endtask

  // Consumer: mode 0 always ready; mode 1 stalls until all bytes are sent, then toggles.
  task automatic consumer(input int mode);
    bit held = 1'b0;
    xfers = 0;
    WORD_READY = (mode == 0);
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLK);
      if (abort || err_a) break;
      if (mode == 1 && bytes_done && !held) begin
        held = 1'b1;
        check("hold_valid", 32'(word_valid_a), 32'd1);
        check("hold_data", word_data_a, 32'h00010203);
        check("hold_last", 32'(word_last_a), 32'd0);
      end
      if (word_valid_a && WORD_READY) begin
        got_a[xfers]    = word_data_a;
        got_b[xfers]    = word_data_b;
        got_last[xfers] = word_last_a;
        xfers++;
        last_xfer_cyc = cyc;
      end
      tick();
      if (xfers == WORDS) break;
      if (mode == 1) WORD_READY = bytes_done ? !WORD_READY : 1'b0;
    end
    WORD_READY = 1'b0;
  endtask

  // Compare captured words against the 0x00..0xFF pattern.
  task automatic check_words(input string pfx, input int exp_n);
    int nbad_a = 0;
    int nbad_b = 0;
    check({pfx, "_xfers"}, xfers, exp_n);
    for (int k = 0; k < xfers; k++) begin
      if (got_a[k] !== exp_word(k) || got_last[k] !== (k == WORDS - 1)) nbad_a++;
      if (got_b[k] !== exp_word(k)) nbad_b++;
    end
    check({pfx, "_bad_words_a"}, nbad_a, 0);
    check({pfx, "_bad_words_b"}, nbad_b, 0);
  endtask

  task automatic full_block_checks(input string pfx, input int exp_done);
    check_words(pfx, WORDS);
    check({pfx, "_word0"}, got_a[0], 32'h00010203);
    check({pfx, "_word127"}, got_a[WORDS-1], 32'hFCFDFEFF);
    check({pfx, "_last127"}, 32'(got_last[WORDS-1]), 32'd1);
    check({pfx, "_done_cnt"}, done_cnt, exp_done);
    check({pfx, "_done_lat"}, done_cyc - last_xfer_cyc, 1);
    check({pfx, "_idle"}, 32'({busy_a, err_a, word_valid_a}), 32'd0);
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; LBA = '0; CONTROLLER_READY = 1'b1;
    BYTE_READY = 1'b0; READBUFFER = '0; WORD_READY = 1'b0; abort = 1'b0;
    clear_capture();
    repeat (2) tick();
    check("rst_flags", 32'({busy_a, done_a, err_a, ctrl_read_a, word_valid_a, word_last_a}), 32'd0);
    check("rst_address", address_a, 32'd0);
    check("rst_data", word_data_a, 32'd0);
    RST = 1'b1;
    repeat (4) tick();

    // Block 1: free-flowing consumer.
    exp_addr_a = 32'h00000600; exp_addr_b = 32'h00000003;
    clear_capture();
    start_req(32'd3);
    check("b1_busy", 32'(busy_a), 32'd1);
    fork
      ctrl_model(512);
      consumer(0);
    join
    repeat (3) tick();
    full_block_checks("b1", 1);

    // Block 2: consumer stalled until the block is collected, then 50% ready.
    clear_capture();
    start_req(32'd3);
    fork
      ctrl_model(512);
      consumer(1);
    join
    repeat (3) tick();
    full_block_checks("b2", 2);

    // Command never accepted: timeout exactly TMO cycles after START.
    CONTROLLER_READY = 1'b0;
    repeat (4) tick();
    start_req(32'd5);
    repeat (TMO - 1) tick();
    check("tmo_err_early", 32'(err_a), 32'd0);
    tick();
    check("tmo_err", 32'(err_a), 32'd1);
    check("tmo_outs", 32'({ctrl_read_a, busy_a, word_valid_a}), 32'd0);
    check("tmo_no_done", done_cnt, 2);

    // Next START clears ERR; byte stream stalls after 37 bytes.
    CONTROLLER_READY = 1'b1;
    repeat (4) tick();
    exp_addr_a = 32'h00000E00; exp_addr_b = 32'h00000007;
    clear_capture();
    start_req(32'd7);
    check("err_clear", 32'(err_a), 32'd0);
    fork
      ctrl_model(37);
      consumer(0);
    join
    tick();
    check("stall_err", 32'(err_a), 32'd1);
    check("stall_outs", 32'({busy_a, word_valid_a, ctrl_read_a}), 32'd0);
    check_words("stall", 9);
    check("stall_no_done", done_cnt, 2);

    // Reset asserted mid-collection.
    exp_addr_a = 32'h00000600; exp_addr_b = 32'h00000003;
    clear_capture();
    start_req(32'd3);
    fork
      ctrl_model(512);
      consumer(0);
      begin
        int c = 0;
        while (bytes_sent < 100 && c < 5000) begin tick(); c++; end
        check("rst_mid_reached", 32'(bytes_sent >= 100), 32'd1);
        #2;
        RST   = 1'b0;
        abort = 1'b1;
        #1;
        check("rst_async_a", 32'({busy_a, done_a, err_a, ctrl_read_a, word_valid_a, word_last_a}), 32'd0);
        check("rst_async_b", 32'({busy_b, done_b, err_b, ctrl_read_b, word_valid_b, word_last_b}), 32'd0);
        check("rst_async_addr", address_a | address_b, 32'd0);
        check("rst_async_data", word_data_a | word_data_b, 32'd0);
      end
    join
    repeat (3) tick();
    abort = 1'b0;
    RST   = 1'b1;
    repeat (4) tick();
    check("rst_no_done", done_cnt, 2);

    // Fresh block after reset release.
    clear_capture();
    start_req(32'd3);
    fork
      ctrl_model(512);
      consumer(0);
    join
    repeat (3) tick();
    full_block_checks("b3", 3);
`ifdef SDREAD_CHECKSUM_EN
    check("checksum_a", 32'(checksum_a), 32'h0000FF00);
    check("checksum_b", 32'(checksum_b), 32'h0000FF00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sd_block_reader.md
Name: sd_block_reader

Overview:
- Sits directly downstream of the SD SPI controller.
- Converts a logical block request (LBA) into a controller read command.
- Collects the 512 bytes the controller delivers and packs them big-endian into 32-bit words in a local 128-word buffer.
- Streams those words to the system over a valid/ready interface; streaming may run concurrently with collection.

Parameters:
- BYTE_ADDR, 1: 1 = SDSC card, ADDRESS = LBA<<9; 0 = SDHC card, ADDRESS = LBA.
- TIMEOUT_CYCLES, 2000000: CLK cycles allowed for command accept or between consecutive bytes before error.
- BLOCK_BYTES, 512: bytes per block; must be a multiple of 4. Word count = BLOCK_BYTES/4.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- START  in  1  one-cycle request pulse; sampled only in IDLE
- LBA  in  32  block number, captured on START
- BUSY  out  1  high from accepted START until DONE or ERR
- DONE  out  1  one-cycle pulse after the last word is consumed
- ERR  out  1  sticky timeout flag; cleared by next accepted START
- CTRL_READ  out  1  read command to controller
- ADDRESS  out  32  card address to controller
- CONTROLLER_READY  in  1  controller idle/accepting
- BYTE_READY  in  1  controller byte strobe (level; edge-detected here)
- READBUFFER  in  8  byte from controller
- WORD_VALID  out  1  WORD_DATA valid
- WORD_READY  in  1  consumer accepts word
- WORD_DATA  out  32  packed word; first byte of block in [31:24]
- WORD_LAST  out  1  high with final word of block

Behaviour:
- Reset values: all outputs 0; state IDLE; pointers, counters and buffer-valid flags cleared. Reset mid-block aborts immediately; no DONE pulse.
- Inputs: BYTE_READY and CONTROLLER_READY pass through a 2-flop synchroniser. A byte event is a 0->1 edge of synchronised BYTE_READY. READBUFFER is sampled on the event cycle; it is stable while BYTE_READY is high.
- State IDLE:
  - START=1 -> capture LBA, compute ADDRESS, BUSY=1, ERR=0, go REQ.
  - START while BUSY is ignored.
- State REQ:
  - Wait for CONTROLLER_READY=1, then assert CTRL_READ and hold it with ADDRESS stable.
  - CONTROLLER_READY falling = command accepted: deassert CTRL_READ next cycle, go COLLECT.
  - Timeout counter runs from REQ entry.
- State COLLECT:
  - Each byte event shifts into a 32-bit pack register and increments byte count (10 bits).
  - Every 4th byte writes the word at wr_ptr (7 bits) and increments wr_ptr.
  - Timeout counter reloads on each byte event.
  - When byte count reaches BLOCK_BYTES -> DRAIN.
- Streaming:
  - WORD_VALID = (rd_ptr != wr_ptr) or the buffer is full-complete.
  - A word transfers when WORD_VALID and WORD_READY are both high in the same cycle; rd_ptr increments.
  - WORD_DATA/WORD_VALID are held while WORD_READY=0.
  - WORD_LAST = (rd_ptr == BLOCK_BYTES/4-1) and WORD_VALID.
  - Buffer depth equals block size, so no overflow is possible. The controller cannot be stalled; backpressure only delays draining.
- State DRAIN:
  - Stays until the last word transfers.
  - Next cycle: DONE=1 for one cycle, BUSY=0, pointers cleared, go IDLE.
- Timeout: counter reaches TIMEOUT_CYCLES in REQ or COLLECT -> ERR=1, CTRL_READ=0, BUSY=0, WORD_VALID=0, buffer discarded, go IDLE. ERR is set with no DONE pulse.
- Simultaneous write and read on the same cycle is legal: the pointer comparison uses pre-update values, and a read of the word being written this cycle is not allowed.
- A byte event in IDLE or REQ is ignored.
- Latency: word k becomes valid 1 cycle after its 4th byte event.

Optional Feature:
- SDREAD_CHECKSUM_EN:
  - Defined: adds output CHECKSUM[15:0], the mod-2^16 sum of all block bytes. It is cleared on START and valid when DONE pulses.
  - Undefined: port and adder absent; behaviour otherwise identical.

Test Plan:
- LBA=3, BYTE_ADDR=1, controller model returns bytes 0x00..0xFF,0x00..0xFF -> ADDRESS=0x00000600. First word 0x00010203, word 127 0xFCFDFEFF with WORD_LAST=1, single DONE pulse.
- Same request with BYTE_ADDR=0 -> ADDRESS=0x00000003; data identical.
- WORD_READY held 0 until all 512 bytes arrive, then toggled 1/0 -> no word lost or duplicated, 128 transfers, DONE after 128th.
- CONTROLLER_READY held 0 with TIMEOUT_CYCLES=100 -> ERR=1 at cycle 100 after START, CTRL_READ=0, BUSY=0, no DONE. Next START clears ERR.
- Byte stream stops after 37 bytes -> ERR after TIMEOUT_CYCLES; WORD_VALID drops; 9 words may have been transferred before the error.
- RST low mid-COLLECT -> all outputs 0 asynchronously. Fresh START after release completes normally. With SDREAD_CHECKSUM_EN, the 0x00..0xFF x2 block gives CHECKSUM=0xFF00.
